// File: rtl/vend_sequencer.sv
// Sequencing controller for the Moore vending machine: coin credit, vend handshake
// with ack timeout, and nickel-by-nickel change/refund. Every output is a flop.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no credit held; first valid coin starts a transaction
// S_COLLECT | partial credit below PRICE; more coins or cancel accepted
// S_VEND    | Vend asserted, waiting for Dispense_ack or timeout
// S_CHANGE  | paying out remaining credit, one nickel every other cycle
module vend_sequencer #(
  parameter int PRICE       = 15,
  parameter int ACK_TIMEOUT = 8,
  parameter int CW          = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Nickel,
  input  logic          Dime,
  input  logic          Quarter,
  input  logic          Cancel,
  input  logic          Dispense_ack,
  output logic          Vend,
  output logic          Change_nickel,
  output logic          Coin_reject,
  output logic          Fault,
  output logic [CW-1:0] Credit,
  output logic [1:0]    State_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_VEND    = 2'b10,
    S_CHANGE  = 2'b11
  } state_e;

  localparam logic [CW-1:0] PRICE_C      = CW'(PRICE);
  localparam logic [CW-1:0] NICKEL_C     = CW'(5);
  localparam logic [CW-1:0] DIME_C       = CW'(10);
  localparam logic [CW-1:0] QUARTER_C    = CW'(25);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          vend_q, vend_d;
  logic          change_nickel_q, change_nickel_d;
  logic          coin_reject_q, coin_reject_d;
  logic          fault_q, fault_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          toggle_q, toggle_d;

  logic          any_coin;
  logic          valid_coin;
  logic          multi_coin;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] credit_sum;

  always_comb begin
    any_coin   = Nickel | Dime | Quarter;
    valid_coin = (Nickel ^ Dime ^ Quarter) & ~(Nickel & Dime & Quarter);
    multi_coin = any_coin & ~valid_coin;
    coin_val   = '0;
    if (Nickel)       coin_val = NICKEL_C;
    else if (Dime)    coin_val = DIME_C;
    else if (Quarter) coin_val = QUARTER_C;
    credit_sum = credit_q + coin_val;
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    change_nickel_d = 1'b0;
    coin_reject_d   = 1'b0;
    fault_d         = 1'b0;
    cnt_d           = '0;
    toggle_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (multi_coin) begin
          coin_reject_d = 1'b1;
        end else if (valid_coin) begin
          credit_d = coin_val;
          state_d  = (coin_val >= PRICE_C) ? S_VEND : S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Cancel takes priority; a coin offered alongside it goes back out.
        if (Cancel) begin
          coin_reject_d = any_coin;
          state_d       = S_CHANGE;
        end else if (multi_coin) begin
          coin_reject_d = 1'b1;
        end else if (valid_coin) begin
          credit_d = credit_sum;
          if (credit_sum >= PRICE_C) state_d = S_VEND;
        end
      end

      S_VEND: begin
        coin_reject_d = any_coin;
        if (Dispense_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = any_coin;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (!toggle_q) begin
          change_nickel_d = 1'b1;
          credit_d        = credit_q - NICKEL_C;
          if (credit_q == NICKEL_C) state_d = S_IDLE;
          else                      toggle_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    vend_d = (state_d == S_VEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      vend_q          <= 1'b0;
      change_nickel_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      fault_q         <= 1'b0;
      cnt_q           <= '0;
      toggle_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      vend_q          <= vend_d;
      change_nickel_q <= change_nickel_d;
      coin_reject_q   <= coin_reject_d;
      fault_q         <= fault_d;
      cnt_q           <= cnt_d;
      toggle_q        <= toggle_d;
    end
  end

  assign Vend          = vend_q;
  assign Change_nickel = change_nickel_q;
  assign Coin_reject   = coin_reject_q;
  assign Fault         = fault_q;
  assign Credit        = credit_q;
  assign State_out     = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the machine.
module tb_vend_sequencer;

  localparam int PRICE       = 15;
  localparam int ACK_TIMEOUT = 8;
  localparam int CW          = 6;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_VEND    = 2;
  localparam int M_CHANGE  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Nickel = 1'b0, Dime = 1'b0, Quarter = 1'b0;
  logic          Cancel = 1'b0, Dispense_ack = 1'b0;
  logic          Vend, Change_nickel, Coin_reject, Fault;
  logic [CW-1:0] Credit;
  logic [1:0]    State_out;

  vend_sequencer #(.PRICE(PRICE), .ACK_TIMEOUT(ACK_TIMEOUT), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Nickel       (Nickel),
    .Dime         (Dime),
    .Quarter      (Quarter),
    .Cancel       (Cancel),
    .Dispense_ack (Dispense_ack),
    .Vend         (Vend),
    .Change_nickel(Change_nickel),
    .Coin_reject  (Coin_reject),
    .Fault        (Fault),
    .Credit       (Credit),
    .State_out    (State_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode, credit owed to the customer, time spent waiting on
  // the motor, and whether the next refund cycle is a pay or a pause.
  int m_mode, m_credit, m_wait;
  bit m_pause;
  bit m_vend, m_nick, m_rej, m_fault;

  task automatic model_step(input bit rst, input bit n, input bit d, input bit q,
                            input bit c, input bit a);
    int coins;
    int value;
    coins   = int'(n) + int'(d) + int'(q);
    value   = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
    m_nick  = 0;
    m_rej   = 0;
    m_fault = 0;
    if (rst) begin
      m_mode = M_IDLE; m_credit = 0; m_wait = 0; m_pause = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (coins > 1) m_rej = 1;
          else if (coins == 1) begin
            m_credit = value;
            m_mode   = (m_credit >= PRICE) ? M_VEND : M_COLLECT;
          end
        end
        M_COLLECT: begin
          if (c) begin
            m_rej   = (coins > 0);
            m_mode  = M_CHANGE;
            m_pause = 0;
          end else if (coins > 1) m_rej = 1;
          else if (coins == 1) begin
            m_credit += value;
            if (m_credit >= PRICE) m_mode = M_VEND;
          end
        end
        M_VEND: begin
          m_rej = (coins > 0);
          m_wait++;
          if (a) begin
            m_credit -= PRICE;
            m_mode    = (m_credit == 0) ? M_IDLE : M_CHANGE;
            m_pause   = 0;
            m_wait    = 0;
          end else if (m_wait >= ACK_TIMEOUT) begin
            m_fault = 1;
            m_mode  = M_CHANGE;
            m_pause = 0;
            m_wait  = 0;
          end
        end
        default: begin
          m_rej = (coins > 0);
          if (!m_pause) begin
            m_nick    = 1;
            m_credit -= 5;
            if (m_credit == 0) m_mode = M_IDLE;
          end
          m_pause = !m_pause;
        end
      endcase
    end
    m_vend = (m_mode == M_VEND);
  endtask

  int seen_nick, seen_fault, seen_vend, seen_rej;

  task automatic clear_seen();
    seen_nick = 0; seen_fault = 0; seen_vend = 0; seen_rej = 0;
  endtask

  task automatic cyc(input bit n, input bit d, input bit q, input bit c, input bit a,
                     input bit rst = 1'b0);
    reset = rst; Nickel = n; Dime = d; Quarter = q; Cancel = c; Dispense_ack = a;
    @(posedge clk);
    model_step(rst, n, d, q, c, a);
    #1;
    check("state",  32'(State_out),     32'(m_mode));
    check("credit", 32'(Credit),        32'(m_credit));
    check("vend",   32'(Vend),          32'(m_vend));
    check("nickel", 32'(Change_nickel), 32'(m_nick));
    check("reject", 32'(Coin_reject),   32'(m_rej));
    check("fault",  32'(Fault),         32'(m_fault));
    seen_nick  += int'(Change_nickel);
    seen_fault += int'(Fault);
    seen_vend  += int'(Vend);
    seen_rej   += int'(Coin_reject);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    m_mode = M_IDLE; m_credit = 0; m_wait = 0; m_pause = 0;
    m_vend = 0; m_nick = 0; m_rej = 0; m_fault = 0;
    clear_seen();

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_state", 32'(State_out), 0);
    check("rst_credit", 32'(Credit), 0);

    // Nickel + Dime -> exact price, no change
    clear_seen();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("s1_state", 32'(State_out), 2);
    check("s1_vend", 32'(Vend), 1);
    cyc(0, 0, 0, 0, 1);
    check("s1_vend_off", 32'(Vend), 0);
    check("s1_credit", 32'(Credit), 0);
    check("s1_idle", 32'(State_out), 0);
    idle(4);
    check("s1_nicks", 32'(seen_nick), 0);

    // Quarter -> 10 cents change as two nickels
    clear_seen();
    cyc(0, 0, 1, 0, 0);
    check("s2_vend", 32'(Vend), 1);
    cyc(0, 0, 0, 0, 1);
    check("s2_credit", 32'(Credit), 10);
    check("s2_change", 32'(State_out), 3);
    idle(6);
    check("s2_nicks", 32'(seen_nick), 2);
    check("s2_end_credit", 32'(Credit), 0);

    // Dime then Cancel -> full refund, never vends
    clear_seen();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(6);
    check("s3_nicks", 32'(seen_nick), 2);
    check("s3_novend", 32'(seen_vend), 0);
    // Dime + Cancel together: coin rejected, only prior credit refunded
    clear_seen();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    check("s3_reject", 32'(Coin_reject), 1);
    idle(6);
    check("s3b_nicks", 32'(seen_nick), 2);

    // Two coins at once in IDLE, then a coin during VEND
    clear_seen();
    cyc(1, 1, 0, 0, 0);
    check("s4_reject", 32'(Coin_reject), 1);
    check("s4_credit", 32'(Credit), 0);
    check("s4_state", 32'(State_out), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("s4_vend_reject", 32'(Coin_reject), 1);
    check("s4_vend_credit", 32'(Credit), 15);
    cyc(0, 0, 0, 0, 1);
    idle(3);

    // Motor never acks -> Fault, 20 cents refunded
    clear_seen();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(ACK_TIMEOUT);
    check("s5_fault", 32'(Fault), 1);
    check("s5_vend_off", 32'(Vend), 0);
    idle(12);
    check("s5_faults", 32'(seen_fault), 1);
    check("s5_nicks", 32'(seen_nick), 4);
    check("s5_idle", 32'(State_out), 0);
    // Ack on the last allowed cycle is a success
    clear_seen();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(ACK_TIMEOUT - 1);
    cyc(0, 0, 0, 0, 1);
    check("s5b_fault", 32'(Fault), 0);
    idle(6);
    check("s5b_faults", 32'(seen_fault), 0);
    check("s5b_nicks", 32'(seen_nick), 1);

    // Reset in the middle of paying change
    clear_seen();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("s6_first_pulse", 32'(Change_nickel), 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("s6_rst_state", 32'(State_out), 0);
    check("s6_rst_credit", 32'(Credit), 0);
    check("s6_rst_nick", 32'(Change_nickel), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("s6_vend", 32'(Vend), 1);
    cyc(0, 0, 0, 0, 1);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit n, d, q, c, a, rs;
      r = $urandom_range(0, 99);
      n = 0; d = 0; q = 0;
      if (r < 20) begin
        case ($urandom_range(0, 2))
          0:       n = 1;
          1:       d = 1;
          default: q = 1;
        endcase
      end else if (r < 24) begin
        n = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        q = 1'($urandom_range(0, 1));
      end
      c  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(n, d, q, c, a, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
